// File: rtl/amo_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// amo_sequencer_pkg
//   Shared definitions for the AMO read-modify-write path: AMO op encodings,
//   sequencer FSM state encodings and the highest legal op code. Imported by
//   the sequencer, its ALU and the decode/control logic so all agree on codes.
// ---------------------------------------------------------------------------
package amo_sequencer_pkg;

    typedef enum logic [3:0] {
        AMO_SWAP = 4'd0,
        AMO_ADD  = 4'd1,
        AMO_AND  = 4'd2,
        AMO_OR   = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_MAX  = 4'd5,
        AMO_MIN  = 4'd6,
        AMO_MAXU = 4'd7,
        AMO_MINU = 4'd8
    } amo_op_e;

    // Any op code above this is rejected without touching memory.
    localparam logic [3:0] AMO_OP_LAST = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MOD  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } amo_state_e;

endpackage

// File: rtl/amo_alu.sv
// ---------------------------------------------------------------------------
// amo_alu
//   Combinational AMO modify step: new = f(op, old, rs2).
//   Ports: op (AMO op code), old_val (word read from memory),
//          rs2_val (register operand), new_val (word to write back).
//   MAX/MIN compare signed, MAXU/MINU unsigned; on a tie the old value wins.
// ---------------------------------------------------------------------------
module amo_alu
    import amo_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] new_val
);

    logic rs2_lt_s, rs2_gt_s, rs2_lt_u, rs2_gt_u;

    assign rs2_lt_s = $signed(rs2_val) < $signed(old_val);
    assign rs2_gt_s = $signed(rs2_val) > $signed(old_val);
    assign rs2_lt_u = rs2_val < old_val;
    assign rs2_gt_u = rs2_val > old_val;

    always_comb begin
        new_val = old_val;
        case (op)
            AMO_SWAP: new_val = rs2_val;
            AMO_ADD:  new_val = old_val + rs2_val;
            AMO_AND:  new_val = old_val & rs2_val;
            AMO_OR:   new_val = old_val | rs2_val;
            AMO_XOR:  new_val = old_val ^ rs2_val;
            AMO_MAX:  new_val = rs2_gt_s ? rs2_val : old_val;
            AMO_MIN:  new_val = rs2_lt_s ? rs2_val : old_val;
            AMO_MAXU: new_val = rs2_gt_u ? rs2_val : old_val;
            AMO_MINU: new_val = rs2_lt_u ? rs2_val : old_val;
            default:  new_val = old_val;
        endcase
    end

endmodule

// File: rtl/amo_sequencer.sv
// ---------------------------------------------------------------------------
// amo_sequencer
//   Multi-cycle read-modify-write sequencer for RV32A AMO*.W. Accepts one
//   request, reads the word, computes the new value, writes it back and
//   returns the old value for rd.
//   Ports:
//     clk, rst            clock; asynchronous active-low reset
//     start/op/rs1_addr/rs2_data/rd_idx   request, sampled when idle
//     busy                request in flight
//     done/err/rd_we/rd_waddr/rd_wdata    registered completion + rd write
//     mem_req/mem_we/mem_addr/mem_wdata   memory request, held until ready
//     mem_ready/mem_rdata                 memory handshake and read data
//   A memory phase that sees TIMEOUT cycles without mem_ready ends with err
//   (TIMEOUT=0 disables this).
// ---------------------------------------------------------------------------
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [4:0]        rd_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_we,
    output logic [4:0]        rd_waddr,
    output logic [XLEN-1:0]   rd_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    amo_state_e        state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   rs2_q, old_q, new_q, alu_new;
    logic [4:0]        rd_idx_q;
    logic              fail_q;
    logic [CNT_W-1:0]  wait_q;
    logic              bad_req, timeout_hit, in_mem;

    amo_alu #(.XLEN(XLEN)) u_alu (
        .op      (op_q),
        .old_val (old_q),
        .rs2_val (rs2_q),
        .new_val (alu_new)
    );

    assign bad_req = (rs1_addr[1:0] != 2'b00) || (op > AMO_OP_LAST);
    assign in_mem  = (state_q == S_RD) || (state_q == S_WR);

    // Fires on the cycle whose stall would bring the wait count to TIMEOUT,
    // so mem_req is high for exactly TIMEOUT unanswered cycles.
    assign timeout_hit = (TIMEOUT != 0) && !mem_ready &&
                         (wait_q == CNT_W'(TIMEOUT - 1));

    // mem_req is decoded from the state register so reset drops it at once.
    assign busy      = (state_q != S_IDLE);
    assign mem_req   = in_mem;
    assign mem_we    = (state_q == S_WR);
    assign mem_addr  = in_mem ? addr_q : '0;
    assign mem_wdata = (state_q == S_WR) ? new_q : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = bad_req ? S_DONE : S_RD;
            S_RD: begin
                if (mem_ready)        state_d = S_MOD;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_MOD:  state_d = S_WR;
            S_WR:   if (mem_ready || timeout_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            rs2_q    <= '0;
            old_q    <= '0;
            new_q    <= '0;
            rd_idx_q <= '0;
            fail_q   <= 1'b0;
            wait_q   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_we    <= 1'b0;
            rd_waddr <= '0;
            rd_wdata <= '0;
        end else begin
            state_q <= state_d;

            // Completion outputs are registered one cycle behind S_DONE.
            done  <= (state_q == S_DONE);
            err   <= (state_q == S_DONE) && fail_q;
            rd_we <= (state_q == S_DONE) && !fail_q && (rd_idx_q != 5'd0);
            if (state_q == S_DONE) begin
                rd_waddr <= rd_idx_q;
                rd_wdata <= old_q;
            end

            if (state_q == S_IDLE && start) begin
                op_q     <= op;
                addr_q   <= rs1_addr;
                rs2_q    <= rs2_data;
                rd_idx_q <= rd_idx;
                old_q    <= '0;
                fail_q   <= bad_req;
            end

            if (state_q == S_RD && mem_ready) old_q <= mem_rdata;
            if (state_q == S_MOD)             new_q <= alu_new;
            if (in_mem && timeout_hit)        fail_q <= 1'b1;

            // Wait counter restarts on entry to each memory phase.
            if ((state_d == S_RD || state_d == S_WR) && state_d != state_q)
                wait_q <= '0;
            else if (in_mem && !mem_ready)
                wait_q <= wait_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// ---------------------------------------------------------------------------
// tb_amo_sequencer
//   Directed bench: word memory model with programmable ready delays, a
//   stability monitor on the held request, and hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_amo_sequencer;
    import amo_sequencer_pkg::*;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        op = '0;
    logic [ADDR_W-1:0] rs1_addr = '0;
    logic [XLEN-1:0]   rs2_data = '0;
    logic [4:0]        rd_idx = '0;
    logic              busy, done, err, rd_we;
    logic [4:0]        rd_waddr;
    logic [XLEN-1:0]   rd_wdata;
    logic              mem_req, mem_we, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    amo_sequencer #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_addr  (rs1_addr),
        .rs2_data  (rs2_data),
        .rd_idx    (rd_idx),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_we     (rd_we),
        .rd_waddr  (rd_waddr),
        .rd_wdata  (rd_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    int          rdly = 0, wdly = 0;
    bit   [7:0]  wcnt;
    int          cyc, wr_cnt, req_cyc, viol;
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0, pl_data = '0;

    assign mem_ready = mem_req && (int'(wcnt) >= (mem_we ? wdly : rdly));
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_ready) wcnt <= '0;
        else if (wcnt != 8'hFF)    wcnt <= wcnt + 8'd1;
        if (pl_en) mem[pl_addr[9:2]] <= pl_data;
        else if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Request must not move while it is waiting for mem_ready.
    bit          ph, hwe;
    logic [31:0] haddr, hwd;
    always @(negedge clk) begin
        if (mem_req) req_cyc <= req_cyc + 1;
        if (ph && mem_req && (mem_we != hwe || mem_addr != haddr || mem_wdata != hwd))
            viol <= viol + 1;
        ph    <= mem_req && !mem_ready;
        hwe   <= mem_we;
        haddr <= mem_addr;
        hwd   <= mem_wdata;
    end

    // ---------------- checking ----------------
    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One request; returns latency (start edge to done cycle, -1 if none)
    // and the completion outputs sampled in the done cycle. With pulse set,
    // a conflicting start is strobed while the sequencer is busy.
    task automatic run_amo(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] rd, input bit pulse,
                           output int lat, output logic er, output logic we,
                           output logic [4:0] wa, output logic [31:0] wd);
        int k;
        lat = -1; er = 1'bx; we = 1'bx; wa = 'x; wd = 'x;
        @(negedge clk);
        start = 1'b1; op = o; rs1_addr = a; rs2_data = d; rd_idx = rd;
        @(negedge clk);
        start = 1'b0;
        k = cyc;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - k; er = err; we = rd_we; wa = rd_waddr; wd = rd_wdata;
                break;
            end
            if (pulse && i == 2) begin
                chk("busy_mid", {31'd0, busy}, 32'd1);
                start = 1'b1; op = AMO_SWAP; rs1_addr = 32'h200; rs2_data = 32'hDEAD; rd_idx = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // ALU table: op, old, rs2, expected new value.
    logic [3:0]  t_op  [7] = '{AMO_MIN, AMO_MINU, AMO_MAX, AMO_MAXU, AMO_XOR, AMO_AND, AMO_SWAP};
    logic [31:0] t_old [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                               32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678};
    logic [31:0] t_rs2 [7] = '{32'h1, 32'h1, 32'h5, 32'h5, 32'hFF00FF00, 32'hFF00FF00, 32'hCAFEBABE};
    logic [31:0] t_new [7] = '{32'hFFFFFFFF, 32'h1, 32'h5, 32'h80000000,
                               32'h0FF00FF0, 32'hF000F000, 32'hCAFEBABE};

    initial begin
        int lat, w0, r0;
        logic er, we;
        logic [4:0] wa;
        logic [31:0] wd;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_done",   {31'd0, done},    32'd0);
        chk("rst_busy",   {31'd0, busy},    32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_rdwe",   {31'd0, rd_we},   32'd0);
        chk("rst_err",    {31'd0, err},     32'd0);
        chk("rst_wdata",  rd_wdata,         32'd0);
        rst = 1'b1;

        // 1: ADD, ready tied high
        preload(32'h100, 32'd5);
        w0 = wr_cnt;
        run_amo(AMO_ADD, 32'h100, 32'd3, 5'd7, 1'b0, lat, er, we, wa, wd);
        chk("t1_lat",   lat,             32'd4);
        chk("t1_err",   {31'd0, er},     32'd0);
        chk("t1_rdwe",  {31'd0, we},     32'd1);
        chk("t1_waddr", {27'd0, wa},     32'd7);
        chk("t1_wdata", wd,              32'd5);
        chk("t1_mem",   memrd(32'h100),  32'd8);
        chk("t1_nwr",   wr_cnt - w0,     32'd1);

        // 2: ALU table incl. MIN vs MINU on 0xFFFFFFFF
        for (int i = 0; i < 7; i++) begin
            preload(32'h120, t_old[i]);
            run_amo(t_op[i], 32'h120, t_rs2[i], 5'd2, 1'b0, lat, er, we, wa, wd);
            chk($sformatf("t2_mem%0d", i), memrd(32'h120), t_new[i]);
            chk($sformatf("t2_old%0d", i), wd, t_old[i]);
            chk($sformatf("t2_lat%0d", i), lat, 32'd4);
        end

        // 3: misaligned SWAP and illegal op, no memory access
        @(negedge clk);
        r0 = req_cyc;
        run_amo(AMO_SWAP, 32'h102, 32'd1, 5'd5, 1'b0, lat, er, we, wa, wd);
        chk("t3_lat",  lat,         32'd1);
        chk("t3_err",  {31'd0, er}, 32'd1);
        chk("t3_rdwe", {31'd0, we}, 32'd0);
        run_amo(4'd9, 32'h100, 32'd1, 5'd5, 1'b0, lat, er, we, wa, wd);
        chk("t3i_lat", lat,         32'd1);
        chk("t3i_err", {31'd0, er}, 32'd1);
        repeat (2) @(negedge clk);
        chk("t3_noreq", req_cyc - r0, 32'd0);
        chk("t3_mem",   memrd(32'h100), 32'd8);

        // 4: read never answered -> timeout after TMO wait cycles
        rdly = 1000;
        preload(32'h108, 32'd77);
        w0 = wr_cnt; r0 = req_cyc;
        run_amo(AMO_ADD, 32'h108, 32'd1, 5'd6, 1'b0, lat, er, we, wa, wd);
        chk("t4_lat",  lat,         32'd5);
        chk("t4_err",  {31'd0, er}, 32'd1);
        chk("t4_rdwe", {31'd0, we}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t4_reqcyc", req_cyc - r0, TMO);
        chk("t4_nowr",   wr_cnt - w0,  32'd0);
        chk("t4_mem",    memrd(32'h108), 32'd77);
        rdly = 0;

        // 5: delayed ready (3 in RD, 2 in WR), start pulsed while busy
        rdly = 3; wdly = 2;
        preload(32'h10C, 32'h0000F00F);
        w0 = wr_cnt;
        run_amo(AMO_OR, 32'h10C, 32'h12340000, 5'd3, 1'b1, lat, er, we, wa, wd);
        chk("t5_lat",   lat,             32'd9);
        chk("t5_err",   {31'd0, er},     32'd0);
        chk("t5_rdwe",  {31'd0, we},     32'd1);
        chk("t5_waddr", {27'd0, wa},     32'd3);
        chk("t5_wdata", wd,              32'h0000F00F);
        chk("t5_mem",   memrd(32'h10C),  32'h1234F00F);
        repeat (6) @(negedge clk);
        chk("t5_nwr",    wr_cnt - w0,     32'd1);
        chk("t5_idle",   {31'd0, busy},   32'd0);
        chk("t5_stable", viol,            32'd0);
        rdly = 0; wdly = 0;

        // 6: reset during WR, then a normal ADD with rd=0
        wdly = 1000;
        preload(32'h110, 32'd10);
        @(negedge clk);
        start = 1'b1; op = AMO_ADD; rs1_addr = 32'h110; rs2_data = 32'd1; rd_idx = 5'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req && mem_we) break;
            @(negedge clk);
        end
        chk("t6_in_wr", {31'd0, mem_req && mem_we}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_req0",  {31'd0, mem_req}, 32'd0);
        chk("t6_we0",   {31'd0, mem_we},  32'd0);
        chk("t6_busy0", {31'd0, busy},    32'd0);
        chk("t6_done0", {31'd0, done},    32'd0);
        @(negedge clk);
        rst = 1'b1; wdly = 0;
        chk("t6_memkeep", memrd(32'h110), 32'd10);
        run_amo(AMO_ADD, 32'h110, 32'd1, 5'd0, 1'b0, lat, er, we, wa, wd);
        chk("t6_lat",  lat,            32'd4);
        chk("t6_err",  {31'd0, er},    32'd0);
        chk("t6_rdwe", {31'd0, we},    32'd0);
        chk("t6_mem",  memrd(32'h110), 32'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
